rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_mux_arbiter_mux.sv | 14 +
 rtl/rr_mux_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the arbiter state encoding and the width of the stall counter.
package rr_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int TCNT_W = 8;

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Purely combinational N-bit-select data mux.
// Requester i's word occupies bits [i*W +: W] of the flat input.
module nbit_mux #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [(2**N)*W-1:0] in,
    input  logic [N-1:0]        s,
    output logic [W-1:0]        out
);

    assign out = in[s*W +: W];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that grants one of 2**N requesters and muxes its data out.
// A stalled grant is aborted after TMO cycles without downstream acceptance.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N   = 2,
    parameter int W   = 8,
    parameter int TMO = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2**N-1:0]      req,
    input  logic [(2**N)*W-1:0]  in,
    input  logic                 out_ready,
    output logic [N-1:0]         s,
    output logic [2**N-1:0]      grant,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 timeout
);

    localparam int M = 2**N;

    state_t              state;
    logic [N-1:0]        last;
    logic [N-1:0]        winner;
    logic [N-1:0]        cand;
    logic                found;
    logic [TCNT_W-1:0]   tcnt;
    logic [TCNT_W-1:0]   tcnt_nxt;

    // Search starts just after the last served requester and wraps; the
    // N-bit addition wraps modulo 2**N on its own.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= M; k++) begin
            cand = last + N'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign tcnt_nxt = tcnt + TCNT_W'(1);

    // Transfer beats withdrawal, which beats timeout; withdrawal leaves
    // last untouched so the withdrawing requester keeps its place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
            tcnt      <= '0;
            last      <= N'(M - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        s         <= winner;
                        grant     <= M'(1) << winner;
                        out_valid <= 1'b1;
                        tcnt      <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        last      <= s;
                        grant     <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (!req[s]) begin
                        grant     <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (tcnt_nxt == TCNT_W'(TMO)) begin
                        timeout   <= 1'b1;
                        last      <= s;
                        grant     <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    nbit_mux #(.N(N), .W(W)) u_mux (
        .in  (in),
        .s   (s),
        .out (out_data)
    );

endmodule
